// File: rtl/tx_msg_pkg.sv
// Shared types and defaults for the UART Tx message sequencer.
// Optional checksum byte is enabled by defining TX_MSG_SEQ_CHECKSUM_EN.
package tx_msg_pkg;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam logic [2:0]  BAUD_SEL_DEF = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ACK,
      XMIT,
      GAP,
      LAST,
      CSUM
   } state_t;

endpackage

// File: rtl/tx_msg_buf.sv
// DEPTH x DATA_W pattern register file: synchronous write, combinational read,
// entry i resets to i.
module tx_msg_buf
   import tx_msg_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= DATA_W'(i);
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tx_msg_sequencer.sv
// Sends the first N pattern bytes to the UART Tx core with write/busy handshake,
// one-shot or looping, with inter-byte gap, ack timeout and clean stop.
// Define TX_MSG_SEQ_CHECKSUM_EN to append an XOR checksum byte to every pass.
module tx_msg_sequencer
   import tx_msg_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = 4,
   parameter logic [2:0]  BAUD_SEL    = BAUD_SEL_DEF,
   parameter int unsigned GAP_W       = 8,
   parameter int unsigned ACK_TIMEOUT = 15,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [AW:0]       msg_len,
   input  logic [GAP_W-1:0]  gap_cycles,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              Tx_BUSY,
   output logic              Tx_EN,
   output logic              Tx_WR,
   output logic [DATA_W-1:0] Tx_DATA,
   output logic [2:0]        Tx_baud_select,
   output logic              busy,
   output logic [AW-1:0]     byte_idx,
   output logic              done,
   output logic              err
);

   localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state, state_d;
   logic [AW-1:0]     idx_d, last_idx, last_d;
   logic              loop_q, loop_d;
   logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt, gap_cnt_d;
   logic [TO_W-1:0]   ack_cnt, ack_cnt_d;
   logic              stop_pend, stop_d;
   logic              wrap_q, wrap_d;
   logic              wr_d, done_d, err_d;
   logic [DATA_W-1:0] data_d, rd_data;
   logic              buf_we_c, stop_now_c, is_last_c, final_c;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
   logic              in_csum, in_csum_d;
`endif

   assign buf_we_c       = wr_en && (state == IDLE);
   assign Tx_EN          = busy;
   assign Tx_baud_select = BAUD_SEL;

   tx_msg_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .we    (buf_we_c),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (byte_idx),
      .rdata (rd_data)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         byte_idx  <= '0;
         last_idx  <= '0;
         loop_q    <= 1'b0;
         gap_q     <= '0;
         gap_cnt   <= '0;
         ack_cnt   <= '0;
         stop_pend <= 1'b0;
         wrap_q    <= 1'b0;
         Tx_WR     <= 1'b0;
         Tx_DATA   <= '1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
         csum_q    <= '0;
         in_csum   <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         byte_idx  <= idx_d;
         last_idx  <= last_d;
         loop_q    <= loop_d;
         gap_q     <= gap_d;
         gap_cnt   <= gap_cnt_d;
         ack_cnt   <= ack_cnt_d;
         stop_pend <= stop_d;
         wrap_q    <= wrap_d;
         Tx_WR     <= wr_d;
         Tx_DATA   <= data_d;
         busy      <= (state_d != IDLE);
         done      <= done_d;
         err       <= err_d;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
         csum_q    <= csum_d;
         in_csum   <= in_csum_d;
`endif
      end
   end

   assign stop_now_c = stop_pend || stop;
   assign is_last_c  = (byte_idx == last_idx);
`ifdef TX_MSG_SEQ_CHECKSUM_EN
   assign final_c    = in_csum;
`else
   assign final_c    = is_last_c;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      idx_d     = byte_idx;
      last_d    = last_idx;
      loop_d    = loop_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt;
      ack_cnt_d = ack_cnt;
      stop_d    = (state != IDLE) && stop_now_c;
      wrap_d    = wrap_q;
      wr_d      = 1'b0;
      data_d    = Tx_DATA;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
      csum_d    = csum_q;
      in_csum_d = in_csum;
`endif

      case (state)
         IDLE: begin
            if (start) begin
               loop_d = loop_mode;
               gap_d  = gap_cycles;
               if ((msg_len == '0) || (msg_len > (AW+1)'(DEPTH))) begin
                  last_d = AW'(DEPTH - 1);
               end else begin
                  last_d = AW'(msg_len - (AW+1)'(1));
               end
               idx_d   = '0;
               wrap_d  = 1'b0;
               state_d = LOAD;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
               csum_d    = '0;
               in_csum_d = 1'b0;
`endif
            end
         end

         LOAD: begin
            if (!Tx_BUSY) begin
               wr_d      = 1'b1;
               data_d    = rd_data;
               ack_cnt_d = '0;
               state_d   = ACK;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
               if (in_csum) begin
                  data_d = csum_q;
               end else begin
                  csum_d = csum_q ^ rd_data;
               end
`endif
            end
         end

         ACK: begin
            if (Tx_BUSY) begin
               state_d = XMIT;
            end else if (ack_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               ack_cnt_d = ack_cnt + TO_W'(1);
            end
         end

         XMIT: begin
            if (!Tx_BUSY) begin
               if (stop_now_c) begin
                  state_d = final_c ? LAST : IDLE;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
               end else if (is_last_c && !in_csum) begin
                  state_d = CSUM;
`endif
               end else if (final_c) begin
                  state_d = LAST;
               end else if (gap_q == '0) begin
                  idx_d   = byte_idx + AW'(1);
                  state_d = LOAD;
               end else begin
                  gap_cnt_d = '0;
                  wrap_d    = 1'b0;
                  state_d   = GAP;
               end
            end
         end

         // wrap_q marks a gap that follows a pass end, where byte_idx is already 0
         GAP: begin
            if ((gap_cnt + GAP_W'(1)) == gap_q) begin
               idx_d   = wrap_q ? byte_idx : byte_idx + AW'(1);
               state_d = LOAD;
            end else begin
               gap_cnt_d = gap_cnt + GAP_W'(1);
            end
         end

         LAST: begin
            done_d = 1'b1;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
            in_csum_d = 1'b0;
`endif
            if (loop_q && !stop_now_c) begin
               idx_d = '0;
`ifdef TX_MSG_SEQ_CHECKSUM_EN
               csum_d = '0;
`endif
               if (gap_q == '0) begin
                  state_d = LOAD;
               end else begin
                  gap_cnt_d = '0;
                  wrap_d    = 1'b1;
                  state_d   = GAP;
               end
            end else begin
               state_d = IDLE;
            end
         end

`ifdef TX_MSG_SEQ_CHECKSUM_EN
         CSUM: begin
            in_csum_d = 1'b1;
            state_d   = LOAD;
         end
`endif

         default: state_d = IDLE;
      endcase
   end

endmodule
